// File: rtl/vote_pkg.sv
// Shared constants for the multi-candidate voting engine: state encodings,
// default access codes, lockout length and the winner-index width.
package vote_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_TALLY  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [15:0] DEF_OPEN_CODE  = 16'hA5A5;
  localparam logic [15:0] DEF_CLOSE_CODE = 16'h5A5A;
  localparam logic [31:0] DEF_LOCK_CYC   = 32'd500_000_000;

  // Enough bits to index up to eight candidates.
  localparam int WIN_W = 3;

  // True when exactly one bit of the (zero-extended) strobe vector is set.
  function automatic logic f_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/vote_counter.sv
// Saturating per-candidate vote counter with synchronous clear.
// o_sat tells the parent the counter cannot accept another vote.
module vote_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_count;

  // Clear has priority over increment; a full counter never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_sat   = &r_count;
  assign o_count = r_count;

endmodule

// File: rtl/multi_vote_engine.sv
// Multi-candidate voting engine: code-gated open/close, per-candidate
// saturating tallies, a sequential winner scan and a wrong-code lockout.
module multi_vote_engine
  import vote_pkg::*;
#(
  parameter int              N_CAND     = 3,
  parameter int              CNT_W      = 8,
  parameter int              CODE_W     = 16,
  parameter logic [CODE_W-1:0] OPEN_CODE  = CODE_W'(DEF_OPEN_CODE),
  parameter logic [CODE_W-1:0] CLOSE_CODE = CODE_W'(DEF_CLOSE_CODE),
  parameter logic [31:0]     LOCK_CYC   = DEF_LOCK_CYC
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic [CODE_W-1:0]       sw,
  input  logic [N_CAND-1:0]       vote_pulse,
  input  logic                    ov_cv_pulse,
  output logic [1:0]              the_state,
  output logic [N_CAND*CNT_W-1:0] counts,
  output logic [CNT_W+2:0]        total,
  output logic [2:0]              the_winner,
  output logic                    tie,
  output logic                    vote_err,
  output logic                    locked,
  output logic                    enable_leds
);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;

  logic [1:0]       r_state;
  logic [CNT_W+2:0] r_total;
  logic [1:0]       r_fail;
  logic             r_locked;
  logic [31:0]      r_lock_cnt;
  logic [WIN_W-1:0] r_scan;
  logic [CNT_W-1:0] r_max;
  logic [WIN_W-1:0] r_best;
  logic             r_tie_run;
  logic [WIN_W-1:0] r_winner;
  logic             r_tie;
  logic             r_vote_err;

  logic [CNT_W-1:0]  w_cnt [N_CAND];
  logic [N_CAND-1:0] w_sat;
  logic [N_CAND-1:0] w_inc;
  logic              w_ov_open;
  logic              w_ov_close;
  logic              w_in_open;
  logic              w_vote_one;
  logic              w_vote_sat;
  logic              w_vote_ok;
  logic              w_vote_bad;
  logic              w_start;
  logic [CNT_W-1:0]  w_scan_cnt;
  logic [CNT_W-1:0]  w_max_nxt;
  logic [WIN_W-1:0]  w_best_nxt;
  logic              w_tie_nxt;

  // Reset asserts immediately but releases two clock edges later.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_ov_open  = ov_cv_pulse && (sw == OPEN_CODE);
  assign w_ov_close = ov_cv_pulse && (sw == CLOSE_CODE);
  assign w_in_open  = (r_state == ST_OPEN);
  assign w_vote_one = f_one_hot(8'(vote_pulse));
  assign w_vote_sat = |(vote_pulse & w_sat);
  assign w_vote_ok  = w_in_open && w_vote_one && !w_vote_sat;
  assign w_vote_bad = w_in_open && (|vote_pulse) && !(w_vote_one && !w_vote_sat);
  assign w_start    = w_ov_open &&
                      (((r_state == ST_IDLE) && !r_locked) || (r_state == ST_RESULT));
  assign w_inc      = w_vote_ok ? vote_pulse : '0;

  genvar g;
  generate
    for (g = 0; g < N_CAND; g++) begin : g_cand
      vote_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk   (clk_100MHz),
        .i_rst_n (w_rst_n),
        .i_clear (w_start),
        .i_inc   (w_inc[g]),
        .o_count (w_cnt[g]),
        .o_sat   (w_sat[g])
      );
      assign counts[g*CNT_W +: CNT_W] = w_cnt[g];
    end
  endgenerate

  // Select the candidate under scan and fold it into the running maximum.
  always_comb begin
    w_scan_cnt = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (r_scan == WIN_W'(i)) begin
        w_scan_cnt = w_cnt[i];
      end
    end
    w_max_nxt  = r_max;
    w_best_nxt = r_best;
    w_tie_nxt  = r_tie_run;
    if ((r_scan == '0) || (w_scan_cnt > r_max)) begin
      w_max_nxt  = w_scan_cnt;
      w_best_nxt = r_scan;
      w_tie_nxt  = 1'b0;
    end else if (w_scan_cnt == r_max) begin
      w_tie_nxt = 1'b1;
    end
  end

  // Running total follows the same accept/clear decisions as the counters.
  always_ff @(posedge clk_100MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_total <= '0;
    end else if (w_start) begin
      r_total <= '0;
    end else if (w_vote_ok) begin
      r_total <= r_total + (CNT_W+3)'(1);
    end
  end

  // Main control: state transitions, lockout timer, tally scan and error pulse.
  always_ff @(posedge clk_100MHz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_fail     <= 2'd0;
      r_locked   <= 1'b0;
      r_lock_cnt <= '0;
      r_scan     <= '0;
      r_max      <= '0;
      r_best     <= '0;
      r_tie_run  <= 1'b0;
      r_winner   <= '0;
      r_tie      <= 1'b0;
      r_vote_err <= 1'b0;
    end else begin
      r_vote_err <= w_vote_bad;
      case (r_state)
        ST_IDLE: begin
          if (r_locked) begin
            if (r_lock_cnt == '0) begin
              r_locked <= 1'b0;
              r_fail   <= 2'd0;
            end else begin
              r_lock_cnt <= r_lock_cnt - 32'd1;
            end
          end else if (ov_cv_pulse) begin
            if (w_ov_open) begin
              r_state <= ST_OPEN;
              r_fail  <= 2'd0;
            end else begin
              r_fail <= r_fail + 2'd1;
              if (r_fail == 2'd2) begin
                r_locked   <= 1'b1;
                r_lock_cnt <= LOCK_CYC - 32'd1;
              end
            end
          end
        end
        ST_OPEN: begin
          if (w_ov_close) begin
            r_state <= ST_TALLY;
            r_scan  <= '0;
          end
        end
        ST_TALLY: begin
          r_max     <= w_max_nxt;
          r_best    <= w_best_nxt;
          r_tie_run <= w_tie_nxt;
          if (r_scan == WIN_W'(N_CAND - 1)) begin
            r_state  <= ST_RESULT;
            r_scan   <= '0;
            r_winner <= w_best_nxt;
            r_tie    <= w_tie_nxt;
          end else begin
            r_scan <= r_scan + WIN_W'(1);
          end
        end
        default: begin
          if (w_ov_open) begin
            r_state  <= ST_OPEN;
            r_winner <= '0;
            r_tie    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign the_state   = r_state;
  assign total       = r_total;
  assign the_winner  = r_winner;
  assign tie         = r_tie;
  assign vote_err    = r_vote_err;
  assign locked      = r_locked;
  assign enable_leds = (r_state == ST_OPEN);

endmodule

// File: doc/multi_vote_engine.md
MULTI_VOTE_ENGINE -- requirements
Module: multi_vote_engine

Interface
REQ-001 Parameter N_CAND, default 3; number of candidates, legal range 2..8.
REQ-002 Parameter CNT_W, default 8; per-candidate and total count width.
REQ-003 Parameter CODE_W, default 16; width of the open/close code input.
REQ-004 Parameter OPEN_CODE, default 16'hA5A5; code that opens voting.
REQ-005 Parameter CLOSE_CODE, default 16'h5A5A; code that closes voting.
REQ-006 Parameter LOCK_CYC, default 32'd500_000_000; lockout length in clock cycles.
REQ-007 clk_100MHz  input  1  sole clock; all logic on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 sw  input  CODE_W  code presented with ov_cv_pulse.
REQ-010 vote_pulse  input  N_CAND  single-cycle, debounced vote strobes, one bit per candidate.
REQ-011 ov_cv_pulse  input  1  single-cycle, debounced open/close request.
REQ-012 the_state  output  2  FSM state: IDLE=0, OPEN=1, TALLY=2, RESULT=3.
REQ-013 counts  output  N_CAND*CNT_W  packed per-candidate counts; candidate i occupies bits [i*CNT_W +: CNT_W].
REQ-014 total  output  CNT_W+3  sum of all accepted votes.
REQ-015 the_winner  output  3  index of the winning candidate; valid only in RESULT.
REQ-016 tie  output  1  high in RESULT when the maximum count is shared.
REQ-017 vote_err  output  1  one-cycle pulse when a vote is rejected.
REQ-018 locked  output  1  high while code-entry lockout is active.
REQ-019 enable_leds  output  1  high only while the_state==OPEN.

Function
REQ-020 IDLE: ov_cv_pulse with sw==OPEN_CODE and locked==0 SHALL move to OPEN next cycle; counts, total and the fail counter clear.
REQ-021 IDLE: ov_cv_pulse with any other code SHALL increment a 2-bit fail counter; the third consecutive failure SHALL set locked for exactly LOCK_CYC cycles, then clear locked and the fail counter.
REQ-022 While locked==1, ov_cv_pulse SHALL be ignored, including a correct code.
REQ-023 OPEN, exactly one vote_pulse bit set: that candidate's count and total SHALL increment next cycle.
REQ-024 OPEN, two or more vote_pulse bits set: no count SHALL change, and vote_err SHALL pulse for one cycle in the next cycle.
REQ-025 A vote for a candidate whose count is 2^CNT_W-1 SHALL leave all counts and total unchanged, and vote_err SHALL pulse.
REQ-026 vote_pulse outside OPEN SHALL be ignored silently, with no vote_err.
REQ-027 OPEN: ov_cv_pulse with sw==CLOSE_CODE SHALL move to TALLY.
REQ-028 A valid vote in the same cycle as the close SHALL still be counted.
REQ-029 OPEN: ov_cv_pulse with a wrong code SHALL be ignored and SHALL NOT affect the fail counter.
REQ-030 TALLY SHALL scan candidates 0..N_CAND-1, one per cycle, keeping a running max and its index; after exactly N_CAND cycles it SHALL enter RESULT.
REQ-031 Winner rule: strictly greater count replaces the running max, so the lowest index wins a tie; tie=1 if any later candidate equals the final max.
REQ-032 If all counts are zero, the result SHALL be the_winner=0, tie=1.
REQ-033 RESULT SHALL hold counts, winner and tie.
REQ-034 RESULT: ov_cv_pulse with OPEN_CODE SHALL start a new round (OPEN, counts cleared); any other ov_cv_pulse SHALL be ignored.
REQ-035 Simultaneous events in IDLE or RESULT: ov_cv_pulse takes effect and vote_pulse is ignored.

Reset
REQ-036 reset==0 SHALL, asynchronously and from any state including mid-TALLY or mid-lockout, force:
- the_state=IDLE
- counts=0, total=0
- the_winner=0, tie=0
- vote_err=0, locked=0, fail counter=0
- lockout timer=0, scan index=0
REQ-037 Release of reset SHALL be synchronised; the first state change SHALL occur no earlier than the second rising clk_100MHz edge after reset rises.

Structure
REQ-038 Package vote_pkg SHALL hold:
- state encodings
- default OPEN_CODE, CLOSE_CODE and LOCK_CYC
- winner-index width constant
REQ-039 Sub-module vote_counter (saturating CNT_W counter with clear, increment and sat flag) SHALL be instantiated N_CAND times via generate.
REQ-040 Debouncing, clock-enable generation, BCD conversion and display SHALL remain outside this block.

Verification
REQ-041 N_CAND=3: open with A5A5; votes 1,1,2; close with 5A5A -> after 3 TALLY cycles: RESULT, counts={0,1,2} for candidates {2,1,0}, total=3, winner=0, tie=0.
REQ-042 OPEN; vote_pulse=3'b011 -> vote_err=1 for one cycle, all counts unchanged.
REQ-043 Three wrong codes in IDLE with LOCK_CYC=10 -> locked=1 for 10 cycles; an A5A5 sent during lockout is ignored; an A5A5 sent after lockout -> OPEN.
REQ-044 CNT_W=2: four votes for candidate 2 -> count=3, fourth vote raises vote_err; candidates 0 and 1 zero -> winner=2, tie=0.
REQ-045 Two votes each for candidates 0 and 2, then close -> winner=0, tie=1; reset asserted mid-TALLY -> all outputs return to reset values immediately.
